clk_ratio_monitor: RTL



---
 rtl/clk_mon_pkg.sv | 22 ++
 rtl/clk_mon_edge.sv | 41 ++++
 rtl/clk_ratio_monitor.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/clk_mon_pkg.sv
// Shared types and width helpers for clk_ratio_monitor.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam int unsigned STREAK_W = 4;

  // All-ones value of a w-bit counter (w <= 31).
  function automatic int unsigned sat_val(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // Width needed to hold 2*x for a w-bit x without wrap.
  function automatic int unsigned cmp_w(input int unsigned w);
    return w + 32'd1;
  endfunction

endpackage

// File: rtl/clk_mon_edge.sv
// Edge detector for the monitored clock; optional 2-flop synchronizer
// when CLK_MON_SYNC_IN_EN is defined.
module clk_mon_edge (
  input  logic clk,
  input  logic rstn,
  input  logic clk_in,
  output logic rise_c,
  output logic fall_c
);

  logic s_c;
  logic prev_q;

`ifdef CLK_MON_SYNC_IN_EN
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= clk_in;
      sync2_q <= sync1_q;
    end
  end

  assign s_c = sync2_q;
`else
  assign s_c = clk_in;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) prev_q <= 1'b0;
    else       prev_q <= s_c;
  end

  assign rise_c = s_c & ~prev_q;
  assign fall_c = ~s_c & prev_q;

endmodule

// File: rtl/clk_ratio_monitor.sv
// Measures period and high time of a divided clock in clk cycles and checks
// them against EXP_DIV/TOL and 50% duty. Optional macro: CLK_MON_SYNC_IN_EN.
module clk_ratio_monitor
  import clk_mon_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned EXP_DIV = 6,
  parameter int unsigned TOL     = 0,
  parameter int unsigned LOCK_N  = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clk_in,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             meas_valid,
  output logic             match_o,
  output logic             locked,
  output logic             err
);

  localparam int unsigned SAT  = sat_val(CNT_W);
  localparam int unsigned CW   = cmp_w(CNT_W);

  logic rise_c;
  logic fall_c;

  clk_mon_edge u_edge (
    .clk    (clk),
    .rstn   (rstn),
    .clk_in (clk_in),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    hi_cap_q, hi_cap_d;
  logic [CNT_W-1:0]    period_q, period_d;
  logic [CNT_W-1:0]    high_q, high_d;
  logic                meas_valid_q, meas_valid_d;
  logic                match_q, match_d;
  logic                locked_q, locked_d;
  logic                err_q, err_d;
  logic [STREAK_W-1:0] streak_q, streak_d;

  logic             cnt_sat_c;
  logic             timeout_c;
  logic             match_c;
  logic [CNT_W-1:0] per_diff_c;
  logic [CW-1:0]    hi2_c;
  logic [CW-1:0]    cnt_x_c;
  logic [CW-1:0]    duty_diff_c;
  logic [STREAK_W-1:0] streak_inc_c;

  // Period and duty checks on the measurement about to be published.
  always_comb begin
    cnt_sat_c   = (cnt_q == CNT_W'(SAT));
    timeout_c   = (state_q != IDLE) && cnt_sat_c && !rise_c && !fall_c;
    per_diff_c  = (cnt_q >= CNT_W'(EXP_DIV)) ? (cnt_q - CNT_W'(EXP_DIV))
                                             : (CNT_W'(EXP_DIV) - cnt_q);
    hi2_c       = {hi_cap_q, 1'b0};
    cnt_x_c     = CW'(cnt_q);
    duty_diff_c = (hi2_c >= cnt_x_c) ? (hi2_c - cnt_x_c) : (cnt_x_c - hi2_c);
    match_c     = (32'(per_diff_c) <= TOL) && (duty_diff_c <= CW'(1));
    streak_inc_c = (streak_q >= STREAK_W'(LOCK_N)) ? STREAK_W'(LOCK_N)
                                                   : streak_q + STREAK_W'(1);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = rise_c ? CNT_W'(1) : (cnt_sat_c ? cnt_q : cnt_q + CNT_W'(1));
    hi_cap_d     = hi_cap_q;
    period_d     = period_q;
    high_d       = high_q;
    meas_valid_d = 1'b0;
    match_d      = match_q;
    locked_d     = locked_q;
    err_d        = 1'b0;
    streak_d     = streak_q;

    if (timeout_c) begin
      err_d    = 1'b1;
      locked_d = 1'b0;
      streak_d = '0;
      match_d  = 1'b0;
      state_d  = IDLE;
    end else begin
      case (state_q)
        IDLE: if (rise_c) state_d = HIGH;
        HIGH: begin
          if (fall_c) begin
            hi_cap_d = cnt_q;
            state_d  = LOW;
          end
        end
        LOW: begin
          if (rise_c) begin
            period_d     = cnt_q;
            high_d       = hi_cap_q;
            meas_valid_d = 1'b1;
            match_d      = match_c;
            state_d      = HIGH;
            if (match_c) begin
              streak_d = streak_inc_c;
              if (streak_inc_c == STREAK_W'(LOCK_N)) locked_d = 1'b1;
            end else begin
              err_d    = 1'b1;
              streak_d = '0;
              locked_d = 1'b0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hi_cap_q     <= '0;
      period_q     <= '0;
      high_q       <= '0;
      meas_valid_q <= 1'b0;
      match_q      <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      streak_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_cap_q     <= hi_cap_d;
      period_q     <= period_d;
      high_q       <= high_d;
      meas_valid_q <= meas_valid_d;
      match_q      <= match_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
      streak_q     <= streak_d;
    end
  end

  assign period_o   = period_q;
  assign high_o     = high_q;
  assign meas_valid = meas_valid_q;
  assign match_o    = match_q;
  assign locked     = locked_q;
  assign err        = err_q;

endmodule
